// File: rtl/genius_seq_prng.sv
// genius_seq_prng: Galois LFSR colour-sequence generator for the Genius core.
// One SYM_W-bit symbol is produced per accepted request, SYM_W LFSR steps
// per symbol, LSB first. rewind replays the sequence from the last seed.
// Optional build macro: GENIUS_PRNG_NO_REPEAT_EN -- regenerate (up to three
// times) any symbol equal to the previously issued one, then fall back to
// previous + 1.
module genius_seq_prng #(
  parameter int                LFSR_W     = 16,
  parameter int                SYM_W      = 2,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1,
  parameter int                MAX_LEN    = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LFSR_W-1:0]              seed,
  input  logic                           seed_load,
  input  logic                           rewind,
  input  logic                           next_req,
  output logic                           busy,
  output logic                           sym_valid,
  output logic [SYM_W-1:0]               sym_out,
  output logic [$clog2(MAX_LEN+1)-1:0]   seq_idx,
  output logic                           seq_full
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(SYM_W + 1);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, start_q, lfsr_step, seed_eff;
  logic [CNT_W-1:0]  cnt_q;
  logic [SYM_W-1:0]  acc_q, acc_next, final_sym;
  logic              out_bit, last_step, retry;

`ifdef GENIUS_PRNG_NO_REPEAT_EN
  logic [SYM_W-1:0]  prev_q;
  logic              have_prev_q;
  logic [1:0]        retry_q;
`endif

  assign busy     = (state_q != IDLE);
  assign seq_full = (seq_idx == IDX_W'(MAX_LEN));
  // A zero seed would lock the LFSR at zero, so it is replaced.
  assign seed_eff = (seed == '0) ? RESET_SEED : seed;

  // Step datapath: next LFSR value, symbol accumulator and repeat filter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    retry     = 1'b0;
    out_bit   = lfsr_q[0];
    lfsr_step = (lfsr_q >> 1) ^ (out_bit ? TAPS : '0);
    // Bits enter at the MSB so the first step ends up in the LSB after SYM_W shifts.
    acc_next  = (acc_q >> 1) | (SYM_W'(out_bit) << (SYM_W - 1));
    last_step = (cnt_q == CNT_W'(SYM_W - 1));
    final_sym = acc_next;
`ifdef GENIUS_PRNG_NO_REPEAT_EN
    if (have_prev_q && (acc_next == prev_q)) begin
      if (retry_q != 2'd3) retry = 1'b1;
      else                 final_sym = prev_q + SYM_W'(1);
    end
`endif
  end

  // Next-state logic; seed_load and rewind abort to IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (next_req && !seq_full) state_d = GEN;
      GEN:     if (last_step && !retry)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (seed_load || rewind) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // LFSR, symbol assembly, issue strobe and sequence counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is reset; there is no memory array to exempt.
    if (!rst_n) begin
      lfsr_q    <= RESET_SEED;
      start_q   <= RESET_SEED;
      cnt_q     <= '0;
      acc_q     <= '0;
      sym_valid <= 1'b0;
      sym_out   <= '0;
      seq_idx   <= '0;
`ifdef GENIUS_PRNG_NO_REPEAT_EN
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      retry_q     <= '0;
`endif
    end else if (seed_load) begin
      lfsr_q    <= seed_eff;
      start_q   <= seed_eff;
      sym_valid <= 1'b0;
      seq_idx   <= '0;
`ifdef GENIUS_PRNG_NO_REPEAT_EN
      have_prev_q <= 1'b0;
`endif
    end else if (rewind) begin
      lfsr_q    <= start_q;
      sym_valid <= 1'b0;
      seq_idx   <= '0;
`ifdef GENIUS_PRNG_NO_REPEAT_EN
      have_prev_q <= 1'b0;
`endif
    end else begin
      sym_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
`ifdef GENIUS_PRNG_NO_REPEAT_EN
          retry_q <= '0;
`endif
        end
        GEN: begin
          lfsr_q <= lfsr_step;
          cnt_q  <= last_step ? '0 : cnt_q + CNT_W'(1);
          acc_q  <= last_step ? final_sym : acc_next;
`ifdef GENIUS_PRNG_NO_REPEAT_EN
          if (retry) retry_q <= retry_q + 2'd1;
`endif
        end
        DONE: begin
          sym_valid <= 1'b1;
          sym_out   <= acc_q;
          if (!seq_full) seq_idx <= seq_idx + IDX_W'(1);
`ifdef GENIUS_PRNG_NO_REPEAT_EN
          prev_q      <= acc_q;
          have_prev_q <= 1'b1;
`endif
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_genius_seq_prng.sv
// tb_genius_seq_prng: scoreboard bench for genius_seq_prng. A reference
// LFSR model predicts each symbol when a request is driven; the expectation
// is queued and popped when sym_valid appears.
module tb_genius_seq_prng;

  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [15:0] RSEED = 16'hACE1;
  localparam int          SYM_W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] seed = '0;
  logic        seed_load = 1'b0, rewind = 1'b0, next_req = 1'b0;
  logic        busy, sym_valid, seq_full;
  logic [1:0]  sym_out;
  logic [5:0]  seq_idx;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_lfsr, m_start;
  logic [1:0]  m_prev;
  logic        m_have_prev;
  logic [1:0]  sb[$];

  genius_seq_prng dut (
    .clk(clk), .rst_n(rst_n), .seed(seed), .seed_load(seed_load),
    .rewind(rewind), .next_req(next_req), .busy(busy), .sym_valid(sym_valid),
    .sym_out(sym_out), .seq_idx(seq_idx), .seq_full(seq_full)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1);
  end

  function automatic logic [1:0] raw_sym();
    logic [1:0] r;
    logic       b;
    for (int k = 0; k < SYM_W; k++) begin
      b      = m_lfsr[0];
      m_lfsr = (m_lfsr >> 1) ^ (b ? TAPS : 16'h0000);
      r[k]   = b;
    end
    return r;
  endfunction

  function automatic logic [1:0] model_sym();
    logic [1:0] r;
    r = raw_sym();
`ifdef GENIUS_PRNG_NO_REPEAT_EN
    if (m_have_prev) begin
      for (int t = 0; t < 3; t++)
        if (r == m_prev) r = raw_sym();
      if (r == m_prev) r = m_prev + 2'd1;
    end
`endif
    m_prev      = r;
    m_have_prev = 1'b1;
    return r;
  endfunction

  task automatic model_restart(input logic [15:0] st);
    m_start     = st;
    m_lfsr      = st;
    m_have_prev = 1'b0;
    sb.delete();
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed      = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    model_restart((s == 16'h0) ? RSEED : s);
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    model_restart(m_start);
  endtask

  // Issue one request and check the symbol and its latency.
  task automatic request_sym(input string tag, output logic [1:0] got);
    int         n;
    logic [1:0] exp;
    next_req = 1'b1;
    sb.push_back(model_sym());
    @(negedge clk);
    next_req = 1'b0;
    n = 1;
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL %s busy after accept: got %b need 1", tag, busy); n_err++;
    end
    while (sym_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    got = sym_out;
    n_vec++;
    if (sym_valid !== 1'b1) begin
      $display("FAIL %s sym_valid timeout: got none in %0d cycles", tag, n); n_err++;
      sb.delete();
    end else begin
      exp = sb.pop_front();
      if (sym_out !== exp) begin
        $display("FAIL %s sym_out: got %0d need %0d", tag, sym_out, exp); n_err++;
      end
`ifndef GENIUS_PRNG_NO_REPEAT_EN
      n_vec++;
      if (n != SYM_W + 2) begin
        $display("FAIL %s latency: got %0d negedges need %0d", tag, n, SYM_W + 2); n_err++;
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, sym_valid, sym_out, seq_idx, seq_full} !== 11'h0 || dut.lfsr_q !== RSEED) begin
      $display("FAIL reset: busy=%b valid=%b sym=%0d idx=%0d full=%b lfsr=%h need zeros lfsr=%h",
               busy, sym_valid, sym_out, seq_idx, seq_full, dut.lfsr_q, RSEED);
      n_err++;
    end
    rst_n = 1'b1;
    model_restart(RSEED);
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [1:0] s;
    do_seed(16'h0001);
    request_sym("t1_sym0", s);
    n_vec++;
    if (s !== 2'd1) begin $display("FAIL t1 first symbol: got %0d need 1", s); n_err++; end
    request_sym("t1_sym1", s);
    n_vec++;
    if (s !== 2'd0) begin $display("FAIL t1 second symbol: got %0d need 0", s); n_err++; end
    n_vec++;
    if (dut.lfsr_q !== 16'h1680) begin
      $display("FAIL t1 lfsr: got %h need 1680", dut.lfsr_q); n_err++;
    end
    n_vec++;
    if (seq_idx !== 6'd2) begin $display("FAIL t1 seq_idx: got %0d need 2", seq_idx); n_err++; end
  endtask

  task automatic test_rewind();
    logic [1:0] first[5];
    logic [1:0] s;
    do_seed(16'h0000);
    n_vec++;
    if (dut.start_q !== RSEED) begin
      $display("FAIL t2 zero seed start: got %h need %h", dut.start_q, RSEED); n_err++;
    end
    for (int i = 0; i < 5; i++) request_sym("t2_first", first[i]);
    do_rewind();
    for (int i = 0; i < 5; i++) begin
      request_sym("t2_replay", s);
      n_vec++;
      if (s !== first[i]) begin
        $display("FAIL t2 replay %0d: got %0d need %0d", i, s, first[i]); n_err++;
      end
    end
    n_vec++;
    if (seq_idx !== 6'd5) begin $display("FAIL t2 seq_idx: got %0d need 5", seq_idx); n_err++; end
  endtask

  task automatic test_full();
    logic [1:0] s;
    logic       saw;
    do_rewind();
    for (int i = 0; i < 32; i++) request_sym("t3_fill", s);
    n_vec++;
    if (seq_full !== 1'b1 || seq_idx !== 6'd32) begin
      $display("FAIL t3 full: got full=%b idx=%0d need 1/32", seq_full, seq_idx); n_err++;
    end
    next_req = 1'b1;
    @(negedge clk);
    next_req = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b0 || sym_valid !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (saw || seq_idx !== 6'd32) begin
      $display("FAIL t3 request when full: activity=%b idx=%0d need 0/32", saw, seq_idx); n_err++;
    end
    do_rewind();
    n_vec++;
    if (seq_idx !== 6'd0 || seq_full !== 1'b0) begin
      $display("FAIL t3 rewind clears: got idx=%0d full=%b need 0/0", seq_idx, seq_full); n_err++;
    end
  endtask

  task automatic test_abort_seed();
    logic [1:0] s;
    logic       saw;
    do_seed(16'h1234);
    request_sym("t4_pre", s);
    next_req = 1'b1;
    @(negedge clk);
    next_req  = 1'b0;
    seed      = 16'h5678;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    model_restart(16'h5678);
    n_vec++;
    if (busy !== 1'b0 || seq_idx !== 6'd0 || sym_valid !== 1'b0) begin
      $display("FAIL t4 abort: got busy=%b idx=%0d valid=%b need 0/0/0", busy, seq_idx, sym_valid);
      n_err++;
    end
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sym_valid !== 1'b0) saw = 1'b1;
    end
    n_vec++;
    if (saw) begin $display("FAIL t4 stray sym_valid: got 1 need 0"); n_err++; end
    request_sym("t4_fresh", s);
  endtask

  task automatic test_back_to_back();
    int         nv;
    logic [1:0] exp;
    logic       saw;
    do_rewind();
    nv = 0;
    next_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sym_valid === 1'b1) begin
        nv++;
        exp = model_sym();
        n_vec++;
        if (sym_out !== exp) begin
          $display("FAIL t5 held sym %0d: got %0d need %0d", nv, sym_out, exp); n_err++;
        end
      end
    end
    next_req = 1'b0;
`ifndef GENIUS_PRNG_NO_REPEAT_EN
    n_vec++;
    if (nv != 4) begin $display("FAIL t5 accept rate: got %0d symbols in 16 cycles need 4", nv); n_err++; end
`endif
    rewind   = 1'b1;
    next_req = 1'b1;
    @(negedge clk);
    rewind   = 1'b0;
    next_req = 1'b0;
    model_restart(m_start);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || sym_valid !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (saw || seq_idx !== 6'd0) begin
      $display("FAIL t5 rewind beats req: activity=%b idx=%0d need 0/0", saw, seq_idx); n_err++;
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] s;
    logic [1:0] last;
    next_req = 1'b1;
    @(negedge clk);
    next_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, sym_valid, sym_out, seq_idx, seq_full} !== 11'h0 || dut.lfsr_q !== RSEED) begin
      $display("FAIL t6 async reset: busy=%b valid=%b sym=%0d idx=%0d lfsr=%h need zeros lfsr=%h",
               busy, sym_valid, sym_out, seq_idx, dut.lfsr_q, RSEED);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_restart(RSEED);
    @(negedge clk);
    request_sym("t6_after_reset", s);
`ifdef GENIUS_PRNG_NO_REPEAT_EN
    do_seed(16'h0001);
    last = 2'bxx;
    for (int i = 0; i < 32; i++) begin
      request_sym("t6_norepeat", s);
      if (i > 0) begin
        n_vec++;
        if (s === last) begin $display("FAIL t6 repeat at %0d: got %0d twice", i, s); n_err++; end
      end
      last = s;
    end
`else
    last = s;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rewind();
    test_full();
    test_abort_seed();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
